// File: rtl/inst_buffer.sv
// -----------------------------------------------------------------------------
// inst_buffer
//
// Purpose:
//   Instruction buffer between fetch and the two-wide decode stage. Entries
//   are held in program order in a circular array. Up to two entries are
//   accepted from fetch per cycle and up to two are presented from the head
//   to the decoders. Fetch-side exceptions ride along with each instruction.
//   A flush discards all buffered entries (mispredict or exception redirect).
//
// Ports:
//   clk                        clock, all state updates on the rising edge
//   rst                        asynchronous active-high reset
//   flush                      drop every entry at the next edge
//   in_valid[1:0]              fetch slot valids (bit 1 only with bit 0)
//   in_pc0/1, in_inst0/1       fetch slot pc and instruction word
//   in_is_exception0/1         fetch exception flag per slot
//   in_exception_cause0/1      fetch exception code per slot
//   in_ready                   room for two entries this cycle
//   out_valid[1:0]             head (bit 0) / head+1 (bit 1) entry valid
//   out_pc0/1, out_inst0/1     head / head+1 entry pc and instruction
//   out_is_exception0/1        head / head+1 exception flag
//   out_exception_cause0/1     head / head+1 exception code
//   out_ready[1:0]             decode consumes slot (bit 1 only with bit 0)
//   count                      number of occupied entries
// -----------------------------------------------------------------------------
module inst_buffer #(
  parameter int DEPTH = 8,
  parameter int PTR_W = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,

  input  logic [1:0]       in_valid,
  input  logic [31:0]      in_pc0,
  input  logic [31:0]      in_pc1,
  input  logic [31:0]      in_inst0,
  input  logic [31:0]      in_inst1,
  input  logic             in_is_exception0,
  input  logic             in_is_exception1,
  input  logic [6:0]       in_exception_cause0,
  input  logic [6:0]       in_exception_cause1,
  output logic             in_ready,

  output logic [1:0]       out_valid,
  output logic [31:0]      out_pc0,
  output logic [31:0]      out_pc1,
  output logic [31:0]      out_inst0,
  output logic [31:0]      out_inst1,
  output logic             out_is_exception0,
  output logic             out_is_exception1,
  output logic [6:0]       out_exception_cause0,
  output logic [6:0]       out_exception_cause1,
  input  logic [1:0]       out_ready,

  output logic [PTR_W:0]   count
);

  // One buffered instruction: 32 + 32 + 1 + 7 = 72 bits.
  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
    logic        is_exception;
    logic [6:0]  cause;
  } entry_t;

  // in_ready threshold: two free slots remain when count <= DEPTH-2.
  localparam logic [PTR_W:0] READY_MAX = (PTR_W+1)'(DEPTH - 2);

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  entry_t             mem_q [DEPTH];
  entry_t             mem_d [DEPTH];
  logic [PTR_W-1:0]   head_q;
  logic [PTR_W-1:0]   head_d;
  logic [PTR_W-1:0]   tail_q;
  logic [PTR_W-1:0]   tail_d;
  logic [PTR_W:0]     count_q;
  logic [PTR_W:0]     count_d;

  // ---------------------------------------------------------------------------
  // Derived control
  // ---------------------------------------------------------------------------
  logic [PTR_W-1:0]   head_p1;
  logic [PTR_W-1:0]   tail_p1;
  logic [1:0]         enq_n;
  logic [1:0]         deq_n;
  logic               enq_ok;
  entry_t             in_entry0;
  entry_t             in_entry1;
  entry_t             head_entry;
  entry_t             next_entry;

  // Pointers are PTR_W bits wide and DEPTH is a power of two, so the
  // natural overflow of the adders gives the modulo-DEPTH wrap.
  assign head_p1 = head_q + PTR_W'(1);
  assign tail_p1 = tail_q + PTR_W'(1);

  // in_ready looks only at registered occupancy; a dequeue in the same
  // cycle never frees space, which keeps out_ready off the in_ready path.
  assign in_ready  = (count_q <= READY_MAX);
  assign out_valid = {(count_q >= (PTR_W+1)'(2)), (count_q >= (PTR_W+1)'(1))};

  // Writes are suppressed during flush so the discarded cycle leaves no trace.
  assign enq_ok = in_ready & ~flush;

  assign in_entry0 = '{pc: in_pc0, inst: in_inst0,
                       is_exception: in_is_exception0, cause: in_exception_cause0};
  assign in_entry1 = '{pc: in_pc1, inst: in_inst1,
                       is_exception: in_is_exception1, cause: in_exception_cause1};

  always_comb begin
    enq_n = 2'd0;
    if (in_ready) begin
      enq_n = {1'b0, in_valid[0]} + {1'b0, in_valid[1]};
    end
  end

  // Slot 1 is only honoured together with slot 0 on the decode side.
  always_comb begin
    deq_n = 2'd0;
    if (out_valid[0] && out_ready[0]) begin
      if (out_valid[1] && out_ready[1]) begin
        deq_n = 2'd2;
      end else begin
        deq_n = 2'd1;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Pointer / occupancy next state. Flush overrides enqueue and dequeue.
  // ---------------------------------------------------------------------------
  always_comb begin
    head_d  = head_q + PTR_W'(deq_n);
    tail_d  = tail_q + PTR_W'(enq_n);
    count_d = count_q + (PTR_W+1)'(enq_n) - (PTR_W+1)'(deq_n);
    if (flush) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Entry storage. Each entry is cleared on reset so the read ports never
  // present X after reset, even for slots that were never written.
  // ---------------------------------------------------------------------------
  generate
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
      logic wr_slot0;
      logic wr_slot1;

      assign wr_slot0 = enq_ok & in_valid[0] & (tail_q  == PTR_W'(gi));
      assign wr_slot1 = enq_ok & in_valid[1] & (tail_p1 == PTR_W'(gi));

      // With DEPTH >= 4, tail and tail+1 never alias the same entry.
      always_comb begin
        mem_d[gi] = mem_q[gi];
        if (wr_slot0) begin
          mem_d[gi] = in_entry0;
        end else if (wr_slot1) begin
          mem_d[gi] = in_entry1;
        end
      end

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          mem_q[gi] <= '0;
        end else begin
          mem_q[gi] <= mem_d[gi];
        end
      end
    end
  endgenerate

  // ---------------------------------------------------------------------------
  // Read ports: straight from registered state, no enqueue bypass.
  // ---------------------------------------------------------------------------
  assign head_entry = mem_q[head_q];
  assign next_entry = mem_q[head_p1];

  assign out_pc0              = head_entry.pc;
  assign out_inst0            = head_entry.inst;
  assign out_is_exception0    = head_entry.is_exception;
  assign out_exception_cause0 = head_entry.cause;

  assign out_pc1              = next_entry.pc;
  assign out_inst1            = next_entry.inst;
  assign out_is_exception1    = next_entry.is_exception;
  assign out_exception_cause1 = next_entry.cause;

  assign count = count_q;

endmodule

// File: tb/tb_inst_buffer.sv
// -----------------------------------------------------------------------------
// tb_inst_buffer
//
// Directed bench for inst_buffer (DEPTH = 8). Inputs are driven 1 ns after the
// rising edge; outputs are checked 1 ns after the edge that consumed them.
// -----------------------------------------------------------------------------
module tb_inst_buffer;

  localparam int DEPTH = 8;
  localparam int PTR_W = $clog2(DEPTH);

  logic             clk;
  logic             rst;
  logic             flush;
  logic [1:0]       in_valid;
  logic [31:0]      in_pc0, in_pc1, in_inst0, in_inst1;
  logic             in_is_exception0, in_is_exception1;
  logic [6:0]       in_exception_cause0, in_exception_cause1;
  logic             in_ready;
  logic [1:0]       out_valid;
  logic [31:0]      out_pc0, out_pc1, out_inst0, out_inst1;
  logic             out_is_exception0, out_is_exception1;
  logic [6:0]       out_exception_cause0, out_exception_cause1;
  logic [1:0]       out_ready;
  logic [PTR_W:0]   count;

  int tests_run;
  int tests_failed;

  inst_buffer #(.DEPTH(DEPTH)) dut (
    .clk                  (clk),
    .rst                  (rst),
    .flush                (flush),
    .in_valid             (in_valid),
    .in_pc0               (in_pc0),
    .in_pc1               (in_pc1),
    .in_inst0             (in_inst0),
    .in_inst1             (in_inst1),
    .in_is_exception0     (in_is_exception0),
    .in_is_exception1     (in_is_exception1),
    .in_exception_cause0  (in_exception_cause0),
    .in_exception_cause1  (in_exception_cause1),
    .in_ready             (in_ready),
    .out_valid            (out_valid),
    .out_pc0              (out_pc0),
    .out_pc1              (out_pc1),
    .out_inst0            (out_inst0),
    .out_inst1            (out_inst1),
    .out_is_exception0    (out_is_exception0),
    .out_is_exception1    (out_is_exception1),
    .out_exception_cause0 (out_exception_cause0),
    .out_exception_cause1 (out_exception_cause1),
    .out_ready            (out_ready),
    .count                (count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] observed,
                       input logic [31:0] expected);
    tests_run++;
    assert (observed === expected) else begin
      tests_failed++;
      $error("FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  // Advance one edge, then settle away from it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_pair(input logic [1:0] v, input logic [31:0] pc_a,
                            input logic [31:0] pc_b);
    in_valid = v;
    in_pc0   = pc_a;
    in_pc1   = pc_b;
    in_inst0 = pc_a ^ 32'h0000_0013;
    in_inst1 = pc_b ^ 32'h0000_0013;
  endtask

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    rst = 1'b1;
    flush = 1'b0;
    in_valid = 2'b00;
    in_pc0 = '0; in_pc1 = '0; in_inst0 = '0; in_inst1 = '0;
    in_is_exception0 = 1'b0; in_is_exception1 = 1'b0;
    in_exception_cause0 = '0; in_exception_cause1 = '0;
    out_ready = 2'b00;

    // ---- Reset then idle
    step();
    step();
    rst = 1'b0;
    step();
    check("rst_out_valid", 32'(out_valid), 32'h0);
    check("rst_in_ready",  32'(in_ready),  32'h1);
    check("rst_count",     32'(count),     32'h0);
    check("rst_out_pc0",   out_pc0,        32'h0);
    check("rst_out_inst1", out_inst1,      32'h0);
    $display("[TB] reset: out_valid=%b in_ready=%b count=%0d", out_valid, in_ready, count);

    // ---- Two-wide fill
    drive_pair(2'b11, 32'h1c00_0000, 32'h1c00_0004);
    step();
    check("fill1_count", 32'(count), 32'd2);
    drive_pair(2'b11, 32'h1c00_0008, 32'h1c00_000c);
    step();
    check("fill_count",     32'(count),     32'd4);
    check("fill_out_pc0",   out_pc0,        32'h1c00_0000);
    check("fill_out_pc1",   out_pc1,        32'h1c00_0004);
    check("fill_out_inst0", out_inst0,      32'h1c00_0013);
    check("fill_out_valid", 32'(out_valid), 32'h3);
    $display("[TB] fill: count=%0d pc0=%h pc1=%h", count, out_pc0, out_pc1);

    // ---- Full boundary
    drive_pair(2'b11, 32'h1c00_0010, 32'h1c00_0014);
    step();
    check("full6_count",    32'(count),    32'd6);
    check("full6_in_ready", 32'(in_ready), 32'h1);
    drive_pair(2'b11, 32'h1c00_0018, 32'h1c00_001c);
    step();
    check("full8_count",    32'(count),    32'd8);
    check("full8_in_ready", 32'(in_ready), 32'h0);
    drive_pair(2'b11, 32'h1c00_0020, 32'h1c00_0024);  // dropped
    step();
    check("drop_count",   32'(count), 32'd8);
    check("drop_out_pc0", out_pc0,    32'h1c00_0000);
    // Dequeue one while fetch still pushes: space is not reused this cycle.
    out_ready = 2'b01;
    step();
    check("deq1_count",    32'(count),    32'd7);
    check("deq1_in_ready", 32'(in_ready), 32'h0);
    check("deq1_out_pc0",  out_pc0,       32'h1c00_0004);
    drive_pair(2'b00, 32'h0, 32'h0);
    step();
    check("deq2_count",    32'(count),    32'd6);
    check("deq2_in_ready", 32'(in_ready), 32'h1);
    check("deq2_out_pc0",  out_pc0,       32'h1c00_0008);
    check("deq2_out_pc1",  out_pc1,       32'h1c00_000c);
    $display("[TB] full boundary: count=%0d in_ready=%b", count, in_ready);

    // ---- Drain to two entries, then 20 cycles of enq2 + deq2 across wrap
    out_ready = 2'b11;
    step();
    check("drain4_count", 32'(count), 32'd4);
    step();
    check("drain2_count",   32'(count), 32'd2);
    check("drain2_out_pc0", out_pc0,    32'h1c00_0018);
    for (int k = 0; k < 20; k++) begin
      drive_pair(2'b11, 32'h1c00_0020 + 32'(8 * k), 32'h1c00_0024 + 32'(8 * k));
      step();
      check("stream_count",   32'(count), 32'd2);
      check("stream_out_pc0", out_pc0,    32'h1c00_0020 + 32'(8 * k));
      check("stream_out_pc1", out_pc1,    32'h1c00_0024 + 32'(8 * k));
    end
    $display("[TB] stream: count=%0d last pc0=%h", count, out_pc0);

    // ---- Exception pass-through and partial dequeue
    drive_pair(2'b00, 32'h0, 32'h0);
    out_ready = 2'b11;
    step();
    check("empty_count",     32'(count),     32'd0);
    check("empty_out_valid", 32'(out_valid), 32'h0);
    drive_pair(2'b01, 32'h1c00_0100, 32'h0);
    in_is_exception0    = 1'b1;
    in_exception_cause0 = 7'h08;
    out_ready = 2'b00;
    step();
    check("exc_count",     32'(count),                32'd1);
    check("exc_out_valid", 32'(out_valid),            32'h1);
    check("exc_flag",      32'(out_is_exception0),    32'h1);
    check("exc_cause",     32'(out_exception_cause0), 32'h08);
    check("exc_out_pc0",   out_pc0,                   32'h1c00_0100);
    drive_pair(2'b00, 32'h0, 32'h0);
    in_is_exception0    = 1'b0;
    in_exception_cause0 = 7'h00;
    out_ready = 2'b10;  // slot 1 without slot 0: no dequeue
    step();
    check("ready10_count",   32'(count), 32'd1);
    check("ready10_out_pc0", out_pc0,    32'h1c00_0100);
    $display("[TB] exception: flag=%b cause=%h count=%0d", out_is_exception0, out_exception_cause0, count);

    // ---- Flush priority
    out_ready = 2'b00;
    drive_pair(2'b11, 32'h1c00_0200, 32'h1c00_0204);
    step();
    drive_pair(2'b11, 32'h1c00_0208, 32'h1c00_020c);
    step();
    check("pre_flush_count", 32'(count), 32'd5);
    flush = 1'b1;
    out_ready = 2'b11;
    drive_pair(2'b11, 32'h1c00_0300, 32'h1c00_0304);
    step();
    check("flush_count",     32'(count),     32'd0);
    check("flush_out_valid", 32'(out_valid), 32'h0);
    check("flush_in_ready",  32'(in_ready),  32'h1);
    flush = 1'b0;
    out_ready = 2'b00;
    drive_pair(2'b01, 32'h1c00_0400, 32'h0);
    step();
    check("post_flush_count",   32'(count),     32'd1);
    check("post_flush_out_pc0", out_pc0,        32'h1c00_0400);
    check("post_flush_valid",   32'(out_valid), 32'h1);
    $display("[TB] flush: count=%0d pc0=%h", count, out_pc0);

    // ---- Asynchronous reset mid-operation (no clock edge in between)
    drive_pair(2'b00, 32'h0, 32'h0);
    #2;
    rst = 1'b1;
    #1;
    check("arst_count",   32'(count),    32'd0);
    check("arst_out_pc0", out_pc0,       32'h0);
    check("arst_ready",   32'(in_ready), 32'h1);
    step();
    rst = 1'b0;
    step();
    $display("[TB] async reset: count=%0d pc0=%h", count, out_pc0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
